// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared types and reset constants for core pipeline stage registers
package stage_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ARGS_WIDTH = 8;

    localparam logic [ADDR_WIDTH-1:0] ADDR_INIT = 32'h8000_0000;
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

    // Don't-care encodings of the control codes, used as their idle/reset values
    localparam logic [ARGS_WIDTH-1:0] INST_TYPE_X  = 8'h00;
    localparam logic [ARGS_WIDTH-1:0] INST_NAME_X  = 8'h00;
    localparam logic [ARGS_WIDTH-1:0] RAM_BYT_X    = 8'h00;
    localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_X = 8'h00;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ARGS_WIDTH-1:0] inst_type;
        logic [ARGS_WIDTH-1:0] inst_name;
        logic [ARGS_WIDTH-1:0] ram_byt;
        logic [ARGS_WIDTH-1:0] reg_wr_src;
        logic                  ram_wr_en;
        logic                  reg_wr_en;
        logic [DATA_WIDTH-1:0] alu_res;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] jmp_or_reg_data;
    } exu2lsu_t;

    localparam int EXU2LSU_W = $bits(exu2lsu_t);

    localparam exu2lsu_t EXU2LSU_RST = '{
        pc:              ADDR_INIT,
        inst_type:       INST_TYPE_X,
        inst_name:       INST_NAME_X,
        ram_byt:         RAM_BYT_X,
        reg_wr_src:      REG_WR_SRC_X,
        ram_wr_en:       1'b0,
        reg_wr_en:       1'b0,
        alu_res:         DATA_ZERO,
        rs2_data:        DATA_ZERO,
        jmp_or_reg_data: DATA_ZERO
    };

endpackage

// File: rtl/stage_skid_buf.sv
// rtl/stage_skid_buf.sv - generic 2-entry skid buffer with flush and registered ready
module stage_skid_buf
    import stage_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_sys_clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    skid_state_t  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    // Ready depends only on held state and reset, never on m_tready
    assign s_tready = resetn && (state != SKID_TWO);
    assign m_tvalid = (state != SKID_EMPTY);
    assign m_tdata  = main_q;
    assign in_fire  = s_tvalid && s_tready;
    assign out_fire = m_tvalid && m_tready;

    // Occupancy and entry movement; flush empties but leaves payload registers untouched
    always_ff @(posedge i_sys_clk) begin
        if (!resetn) begin
            state  <= SKID_EMPTY;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (flush) begin
            state <= SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        state  <= SKID_ONE;
                        main_q <= s_tdata;
                    end
                end
                SKID_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= s_tdata;
                    end else if (in_fire) begin
                        state  <= SKID_TWO;
                        skid_q <= s_tdata;
                    end else if (out_fire) begin
                        state <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (out_fire) begin
                        state  <= SKID_ONE;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state <= SKID_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/exu2lsu.sv
// rtl/exu2lsu.sv - EXU to LSU pipeline stage register with skid buffer and stall counter
module exu2lsu
    import stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int ARGS_W = ARGS_WIDTH,
    parameter int CNT_W  = 32
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_sys_flush,
    input  logic              i_sys_valid,
    output logic              o_sys_ready,
    output logic              o_sys_valid,
    input  logic              i_sys_ready,
    input  logic [ADDR_W-1:0] i_exu_pc,
    input  logic [ARGS_W-1:0] i_exu_ctr_inst_type,
    input  logic [ARGS_W-1:0] i_exu_ctr_inst_name,
    input  logic [ARGS_W-1:0] i_exu_ctr_ram_byt,
    input  logic [ARGS_W-1:0] i_exu_ctr_reg_wr_src,
    input  logic              i_exu_ctr_ram_wr_en,
    input  logic              i_exu_ctr_reg_wr_en,
    input  logic [DATA_W-1:0] i_exu_alu_res,
    input  logic [DATA_W-1:0] i_exu_rs2_data,
    input  logic [DATA_W-1:0] i_exu_jmp_or_reg_data,
    output logic [ADDR_W-1:0] o_exu_pc,
    output logic [ARGS_W-1:0] o_exu_ctr_inst_type,
    output logic [ARGS_W-1:0] o_exu_ctr_inst_name,
    output logic [ARGS_W-1:0] o_exu_ctr_ram_byt,
    output logic [ARGS_W-1:0] o_exu_ctr_reg_wr_src,
    output logic              o_exu_ctr_ram_wr_en,
    output logic              o_exu_ctr_reg_wr_en,
    output logic [DATA_W-1:0] o_exu_alu_res,
    output logic [DATA_W-1:0] o_exu_rs2_data,
    output logic [DATA_W-1:0] o_exu_jmp_or_reg_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // The payload layout is owned by stage_pkg; ADDR_W/DATA_W/ARGS_W must match its widths
    exu2lsu_t pay_in;
    exu2lsu_t pay_out;
    logic     stall;

    // Gather incoming fields into the shared payload layout
    always_comb begin
        pay_in                 = EXU2LSU_RST;
        pay_in.pc              = i_exu_pc;
        pay_in.inst_type       = i_exu_ctr_inst_type;
        pay_in.inst_name       = i_exu_ctr_inst_name;
        pay_in.ram_byt         = i_exu_ctr_ram_byt;
        pay_in.reg_wr_src      = i_exu_ctr_reg_wr_src;
        pay_in.ram_wr_en       = i_exu_ctr_ram_wr_en;
        pay_in.reg_wr_en       = i_exu_ctr_reg_wr_en;
        pay_in.alu_res         = i_exu_alu_res;
        pay_in.rs2_data        = i_exu_rs2_data;
        pay_in.jmp_or_reg_data = i_exu_jmp_or_reg_data;
    end

    stage_skid_buf #(
        .W       (EXU2LSU_W),
        .RST_VAL (EXU2LSU_RST)
    ) u_skid (
        .i_sys_clk (i_sys_clk),
        .resetn    (i_sys_rst_n),
        .flush     (i_sys_flush),
        .s_tvalid  (i_sys_valid),
        .s_tready  (o_sys_ready),
        .s_tdata   (pay_in),
        .m_tvalid  (o_sys_valid),
        .m_tready  (i_sys_ready),
        .m_tdata   (pay_out)
    );

    // Unpack; write enables are masked so a bubble can never commit a write
    always_comb begin
        o_exu_pc              = pay_out.pc;
        o_exu_ctr_inst_type   = pay_out.inst_type;
        o_exu_ctr_inst_name   = pay_out.inst_name;
        o_exu_ctr_ram_byt     = pay_out.ram_byt;
        o_exu_ctr_reg_wr_src  = pay_out.reg_wr_src;
        o_exu_ctr_ram_wr_en   = pay_out.ram_wr_en && o_sys_valid;
        o_exu_ctr_reg_wr_en   = pay_out.reg_wr_en && o_sys_valid;
        o_exu_alu_res         = pay_out.alu_res;
        o_exu_rs2_data        = pay_out.rs2_data;
        o_exu_jmp_or_reg_data = pay_out.jmp_or_reg_data;
    end

    assign stall = o_sys_valid && !i_sys_ready;

    // Saturating backpressure counter; only reset clears it
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            o_stall_cnt <= '0;
        end else if (stall && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_exu2lsu.sv
// tb/tb_exu2lsu.sv - directed self-checking bench for exu2lsu
`timescale 1ns/1ps
module tb_exu2lsu;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] pc_i, pc_o;
    logic [GW-1:0] typ_i, typ_o, nam_i, nam_o, byt_i, byt_o, src_i, src_o;
    logic          ram_we_i, ram_we_o, reg_we_i, reg_we_o;
    logic [DW-1:0] alu_i, alu_o, rs2_i, rs2_o, jmp_i, jmp_o;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exu2lsu #(.CNT_W(CW)) dut (
        .i_sys_clk             (clk),
        .i_sys_rst_n           (rst_n),
        .i_sys_flush           (flush),
        .i_sys_valid           (in_valid),
        .o_sys_ready           (in_ready),
        .o_sys_valid           (out_valid),
        .i_sys_ready           (out_ready),
        .i_exu_pc              (pc_i),
        .i_exu_ctr_inst_type   (typ_i),
        .i_exu_ctr_inst_name   (nam_i),
        .i_exu_ctr_ram_byt     (byt_i),
        .i_exu_ctr_reg_wr_src  (src_i),
        .i_exu_ctr_ram_wr_en   (ram_we_i),
        .i_exu_ctr_reg_wr_en   (reg_we_i),
        .i_exu_alu_res         (alu_i),
        .i_exu_rs2_data        (rs2_i),
        .i_exu_jmp_or_reg_data (jmp_i),
        .o_exu_pc              (pc_o),
        .o_exu_ctr_inst_type   (typ_o),
        .o_exu_ctr_inst_name   (nam_o),
        .o_exu_ctr_ram_byt     (byt_o),
        .o_exu_ctr_reg_wr_src  (src_o),
        .o_exu_ctr_ram_wr_en   (ram_we_o),
        .o_exu_ctr_reg_wr_en   (reg_we_o),
        .o_exu_alu_res         (alu_o),
        .o_exu_rs2_data        (rs2_o),
        .o_exu_jmp_or_reg_data (jmp_o),
        .o_stall_cnt           (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an entry whose data fields are derived from its pc
    task automatic offer(input logic v, input logic [31:0] pc, input logic we);
        in_valid = v;
        pc_i     = pc;
        typ_i    = pc[7:0];
        nam_i    = pc[7:0] ^ 8'h3c;
        byt_i    = 8'h02;
        src_i    = 8'h01;
        ram_we_i = we;
        reg_we_i = we;
        alu_i    = pc ^ 32'hA5A5_0000;
        rs2_i    = ~pc;
        jmp_i    = pc + 32'd4;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 32'h0, 1'b0);

        // 1: reset held three cycles, then released
        repeat (3) tick();
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_pc", {32'b0, pc_o}, 64'h8000_0000);
        chk("rst_type", {56'b0, typ_o}, 64'h0);
        chk("rst_alu", {32'b0, alu_o}, 64'h0);
        chk("rst_stall", {60'b0, stall_cnt}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {63'b0, in_ready}, 64'd1);
        chk("rel_valid", {63'b0, out_valid}, 64'd0);

        // 2: full-rate stream, each pc appears one cycle after it is offered
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0);
            tick();
            chk("str_valid", {63'b0, out_valid}, 64'd1);
            chk("str_pc", {32'b0, pc_o}, {32'b0, 32'h8000_0000 + 32'(4 * i)});
            chk("str_ready", {63'b0, in_ready}, 64'd1);
        end
        offer(1'b0, 32'h0, 1'b0);
        tick();
        chk("str_drain", {63'b0, out_valid}, 64'd0);
        chk("str_stall", {60'b0, stall_cnt}, 64'd0);

        // 3: backpressure fills both entries, then drains in order
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0100, 1'b0);
        tick();
        chk("bp_one_ready", {63'b0, in_ready}, 64'd1);
        offer(1'b1, 32'h0000_0104, 1'b0);
        tick();
        offer(1'b0, 32'h0, 1'b0);
        chk("bp_two_ready", {63'b0, in_ready}, 64'd0);
        chk("bp_two_pc", {32'b0, pc_o}, 64'h100);
        tick();
        chk("bp_hold_pc", {32'b0, pc_o}, 64'h100);
        chk("bp_hold_alu", {32'b0, alu_o}, 64'hA5A5_0100);
        chk("bp_stall", {60'b0, stall_cnt}, 64'd2);
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", {63'b0, out_valid}, 64'd1);
        chk("bp_b_pc", {32'b0, pc_o}, 64'h104);
        chk("bp_b_rs2", {32'b0, rs2_o}, {32'b0, ~32'h104});
        chk("bp_b_jmp", {32'b0, jmp_o}, 64'h108);
        chk("bp_b_ready", {63'b0, in_ready}, 64'd1);
        tick();
        chk("bp_empty", {63'b0, out_valid}, 64'd0);
        chk("bp_stall_end", {60'b0, stall_cnt}, 64'd2);

        // 4: flush while full with a new entry offered
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0200, 1'b1);
        tick();
        offer(1'b1, 32'h0000_0204, 1'b1);
        tick();
        chk("fl_full", {63'b0, in_ready}, 64'd0);
        chk("fl_we_pre", {63'b0, ram_we_o}, 64'd1);
        flush = 1'b1;
        offer(1'b1, 32'h0000_0300, 1'b1);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        chk("fl_valid", {63'b0, out_valid}, 64'd0);
        chk("fl_ram_we", {63'b0, ram_we_o}, 64'd0);
        chk("fl_reg_we", {63'b0, reg_we_o}, 64'd0);
        chk("fl_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_c", {63'b0, out_valid}, 64'd0);
        end
        // flush in ONE beats a simultaneous accept
        offer(1'b1, 32'h0000_0310, 1'b0);
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        offer(1'b1, 32'h0000_0314, 1'b0);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 1'b0);
        chk("fl_one_valid", {63'b0, out_valid}, 64'd0);

        // 5: bubble after a write-enabled entry must not show its enable
        offer(1'b1, 32'h0000_0400, 1'b1);
        tick();
        chk("bub_we_on", {63'b0, reg_we_o}, 64'd1);
        offer(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bub_valid", {63'b0, out_valid}, 64'd0);
        chk("bub_reg_we", {63'b0, reg_we_o}, 64'd0);
        chk("bub_ram_we", {63'b0, ram_we_o}, 64'd0);

        // 6: counter saturates, then reset mid-stall clears everything
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0500, 1'b0);
        tick();
        offer(1'b0, 32'h0, 1'b0);
        repeat (20) tick();
        chk("sat_cnt", {60'b0, stall_cnt}, 64'd15);
        tick();
        chk("sat_hold", {60'b0, stall_cnt}, 64'd15);
        offer(1'b1, 32'h0000_0504, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cnt", {60'b0, stall_cnt}, 64'd0);
        chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'd0);
        chk("mid_rst_pc", {32'b0, pc_o}, 64'h8000_0000);
        offer(1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", {63'b0, in_ready}, 64'd1);
        chk("mid_rel_valid", {63'b0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
